game_ctrl: RTL and testbench

Top-level game sequencer for the vertical-scroll playfield. Owns the game state machine (attract, play, hit, game over) and drives the scroll datapath's reset and move inputs. Tracks lives and high score, and produces a hit-flash flag for the renderer. Sits between the button inputs, the collision detector and the scroll/score datapath.

---
 rtl/game_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 36 +++
 rtl/game_ctrl.sv | 159 +++++++++++++++
 tb/tb_game_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared state encoding and default timing constants for the vertical-scroll game.
package game_pkg;

   typedef enum logic [1:0] {
      ST_ATTRACT = 2'd0,
      ST_PLAY    = 2'd1,
      ST_HIT     = 2'd2,
      ST_OVER    = 2'd3
   } state_e;

   localparam int unsigned CNT_W   = 8;
   localparam int unsigned LIVES_W = 2;
   localparam int unsigned SCORE_W = 8;

   localparam int unsigned DEF_LIVES        = 3;
   localparam int unsigned DEF_HIT_FRAMES   = 60;
   localparam int unsigned DEF_FLASH_FRAMES = 8;
   localparam int unsigned DEF_OVER_FRAMES  = 120;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, frame-rate sampling and rising-edge detect.
// press pulses once per physical press, in the same cycle as frame_tick.
module btn_debounce (
   input  logic clk,
   input  logic reset,
   input  logic frame_tick,
   input  logic btn_raw,
   output logic press
);

   logic       sync1_q, sync2_q;
   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d = hist_q;
      if (frame_tick) begin
         hist_d = {hist_q[0], sync2_q};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 2'b00;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         hist_q  <= hist_d;
      end
   end

   // High on this tick and the previous one, low on the tick before that.
   assign press = frame_tick & sync2_q & hist_q[0] & ~hist_q[1];

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: attract/play/hit/over FSM, lives and high-score tracking,
// scroll datapath control and hit-flash generation. All outputs registered.
module game_ctrl
   import game_pkg::*;
#(
   parameter int unsigned LIVES        = DEF_LIVES,
   parameter int unsigned HIT_FRAMES   = DEF_HIT_FRAMES,
   parameter int unsigned FLASH_FRAMES = DEF_FLASH_FRAMES,
   parameter int unsigned OVER_FRAMES  = DEF_OVER_FRAMES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start_btn,
   input  logic               move_btn,
   input  logic               collision,
   input  logic [SCORE_W-1:0] score,
   output logic               scroll_reset,
   output logic               scroll_move,
   output logic [1:0]         state,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_high,
   output logic               flash
);

   state_e               state_q, state_d;
   logic [LIVES_W-1:0]   lives_q, lives_d;
   logic [SCORE_W-1:0]   high_q, high_d;
   logic                 new_high_q, new_high_d;
   logic                 flash_q, flash_d;
   logic [CNT_W-1:0]     flash_cnt_q, flash_cnt_d;
   logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic                 scroll_reset_q, scroll_reset_d;
   logic                 scroll_move_q, scroll_move_d;
   logic                 start_press;
   logic [CNT_W-1:0]     frame_cnt_inc;
   logic [CNT_W-1:0]     flash_cnt_inc;

   btn_debounce u_start_db (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .btn_raw    (start_btn),
      .press      (start_press)
   );

   assign frame_cnt_inc = frame_cnt_q + CNT_W'(1);
   assign flash_cnt_inc = flash_cnt_q + CNT_W'(1);

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      high_d      = high_q;
      new_high_d  = new_high_q;
      flash_d     = flash_q;
      flash_cnt_d = flash_cnt_q;
      frame_cnt_d = frame_cnt_q;

      if (frame_tick && (frame_cnt_q != CNT_MAX)) begin
         frame_cnt_d = frame_cnt_inc;
      end

      case (state_q)
         ST_ATTRACT: begin
            flash_d = 1'b0;
            if (start_press) begin
               state_d    = ST_PLAY;
               lives_d    = LIVES_W'(LIVES);
               new_high_d = 1'b0;
            end
         end

         ST_PLAY: begin
            // lives_q is always >= 1 here; the guard keeps the counter from wrapping.
            if (collision && (lives_q != '0)) begin
               state_d     = ST_HIT;
               lives_d     = lives_q - LIVES_W'(1);
               flash_d     = 1'b1;
               flash_cnt_d = '0;
            end
         end

         ST_HIT: begin
            if (frame_tick) begin
               if (frame_cnt_inc == CNT_W'(HIT_FRAMES)) begin
                  flash_d = 1'b0;
                  if (lives_q == '0) begin
                     state_d = ST_OVER;
                     if (score > high_q) begin
                        high_d     = score;
                        new_high_d = 1'b1;
                     end
                  end else begin
                     state_d = ST_PLAY;
                  end
               end else if (flash_cnt_inc == CNT_W'(FLASH_FRAMES)) begin
                  flash_d     = ~flash_q;
                  flash_cnt_d = '0;
               end else begin
                  flash_cnt_d = flash_cnt_inc;
               end
            end
         end

         ST_OVER: begin
            // Early presses fall through here and are simply lost.
            if (start_press && (frame_cnt_q >= CNT_W'(OVER_FRAMES))) begin
               state_d = ST_ATTRACT;
            end
         end

         default: begin
            state_d = ST_ATTRACT;
         end
      endcase

      if (state_d != state_q) begin
         frame_cnt_d = '0;
      end

      scroll_reset_d = (state_d == ST_ATTRACT);
      scroll_move_d  = (state_d == ST_PLAY) & move_btn;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_ATTRACT;
         lives_q        <= '0;
         high_q         <= '0;
         new_high_q     <= 1'b0;
         flash_q        <= 1'b0;
         flash_cnt_q    <= '0;
         frame_cnt_q    <= '0;
         scroll_reset_q <= 1'b1;
         scroll_move_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         lives_q        <= lives_d;
         high_q         <= high_d;
         new_high_q     <= new_high_d;
         flash_q        <= flash_d;
         flash_cnt_q    <= flash_cnt_d;
         frame_cnt_q    <= frame_cnt_d;
         scroll_reset_q <= scroll_reset_d;
         scroll_move_q  <= scroll_move_d;
      end
   end

   assign state        = state_q;
   assign lives        = lives_q;
   assign high_score   = high_q;
   assign new_high     = new_high_q;
   assign flash        = flash_q;
   assign scroll_reset = scroll_reset_q;
   assign scroll_move  = scroll_move_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with hand-computed expectations.
module tb_game_ctrl;

   localparam logic [1:0] S_ATTRACT = 2'd0;
   localparam logic [1:0] S_PLAY    = 2'd1;
   localparam logic [1:0] S_HIT     = 2'd2;
   localparam logic [1:0] S_OVER    = 2'd3;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       start_btn;
   logic       move_btn;
   logic       collision;
   logic [7:0] score;
   logic       scroll_reset;
   logic       scroll_move;
   logic [1:0] state;
   logic [1:0] lives;
   logic [7:0] high_score;
   logic       new_high;
   logic       flash;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   game_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .start_btn    (start_btn),
      .move_btn     (move_btn),
      .collision    (collision),
      .score        (score),
      .scroll_reset (scroll_reset),
      .scroll_move  (scroll_move),
      .state        (state),
      .lives        (lives),
      .high_score   (high_score),
      .new_high     (new_high),
      .flash        (flash)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One video frame: a single-cycle frame_tick followed by two idle cycles.
   task automatic frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
   endtask

   // Press (press lands on the second tick) and release start.
   task automatic start_game();
      start_btn = 1'b1;
      repeat (3) step();
      frame();
      frame();
      start_btn = 1'b0;
      repeat (3) step();
      frame();
      frame();
   endtask

   task automatic hit_cycle();
      collision = 1'b1;
      step();
      collision = 1'b0;
      repeat (60) frame();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      frame_tick = 1'b0;
      start_btn  = 1'b0;
      move_btn   = 1'b0;
      collision  = 1'b0;
      score      = 8'd0;
      step();
      step();
      check("rst_state", 32'(state), 32'(S_ATTRACT));
      check("rst_scroll_reset", 32'(scroll_reset), 1);
      check("rst_scroll_move", 32'(scroll_move), 0);
      check("rst_lives", 32'(lives), 0);
      check("rst_high", 32'(high_score), 0);
      check("rst_new_high", 32'(new_high), 0);
      check("rst_flash", 32'(flash), 0);
      reset = 1'b0;
      step();

      // Game 1 start: the first tick only sees one high sample.
      start_btn = 1'b1;
      repeat (3) step();
      frame();
      check("one_tick_no_press", 32'(state), 32'(S_ATTRACT));
      frame_tick = 1'b1;
      check("accept_cycle_scroll_reset", 32'(scroll_reset), 1);
      step();
      frame_tick = 1'b0;
      check("start_state", 32'(state), 32'(S_PLAY));
      check("start_scroll_reset", 32'(scroll_reset), 0);
      check("start_lives", 32'(lives), 3);
      check("start_new_high", 32'(new_high), 0);
      step();
      step();
      frame();
      frame();
      check("hold_stays_play", 32'(state), 32'(S_PLAY));
      start_btn = 1'b0;
      repeat (3) step();
      frame();
      frame();

      // Move mirror with one-cycle delay.
      move_btn = 1'b1;
      check("move_delay", 32'(scroll_move), 0);
      step();
      check("move_hi", 32'(scroll_move), 1);
      move_btn = 1'b0;
      step();
      check("move_lo", 32'(scroll_move), 0);
      move_btn = 1'b1;
      step();
      check("move_hi2", 32'(scroll_move), 1);

      // First hit, collision held for the whole HIT period.
      collision = 1'b1;
      step();
      check("hit1_state", 32'(state), 32'(S_HIT));
      check("hit1_lives", 32'(lives), 2);
      check("hit1_move_forced", 32'(scroll_move), 0);
      check("hit1_flash_entry", 32'(flash), 1);
      move_btn = 1'b0;
      for (int f = 1; f <= 59; f++) begin
         frame();
         if (f == 7)  check("flash_f7", 32'(flash), 1);
         if (f == 8)  check("flash_f8", 32'(flash), 0);
         if (f == 16) check("flash_f16", 32'(flash), 1);
         if (f == 59) begin
            check("flash_f59", 32'(flash), 0);
            check("hit_f59_state", 32'(state), 32'(S_HIT));
            check("hit_invuln_lives", 32'(lives), 2);
         end
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("hit_end_state", 32'(state), 32'(S_PLAY));
      check("hit_end_flash", 32'(flash), 0);
      check("hit_end_lives", 32'(lives), 2);
      step();
      check("recollide_state", 32'(state), 32'(S_HIT));
      check("recollide_lives", 32'(lives), 1);
      collision = 1'b0;

      score = 8'd17;
      repeat (60) frame();
      check("hit2_end_state", 32'(state), 32'(S_PLAY));
      check("hit2_end_lives", 32'(lives), 1);

      // Collision coincident with frame_tick: counter starts HIT at zero.
      collision  = 1'b1;
      frame_tick = 1'b1;
      step();
      collision  = 1'b0;
      frame_tick = 1'b0;
      check("hit3_state", 32'(state), 32'(S_HIT));
      check("hit3_lives", 32'(lives), 0);
      step();
      step();
      repeat (59) frame();
      check("hit3_f59_state", 32'(state), 32'(S_HIT));
      frame();
      check("over_state", 32'(state), 32'(S_OVER));
      check("over_high", 32'(high_score), 17);
      check("over_new_high", 32'(new_high), 1);
      check("over_lives", 32'(lives), 0);
      check("over_scroll_reset", 32'(scroll_reset), 0);

      // Early press in OVER (counter 49 at the accepting tick) is dropped.
      repeat (48) frame();
      start_btn = 1'b1;
      repeat (3) step();
      frame();
      frame();
      check("over_early_press", 32'(state), 32'(S_OVER));
      start_btn = 1'b0;
      repeat (3) step();
      frame();
      frame();
      repeat (76) frame();
      start_btn = 1'b1;
      repeat (3) step();
      frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("over_late_press", 32'(state), 32'(S_ATTRACT));
      check("attract_scroll_reset", 32'(scroll_reset), 1);
      check("attract_high_kept", 32'(high_score), 17);
      start_btn = 1'b0;
      repeat (3) step();
      frame();
      frame();

      // Game 2 ends with an equal score: not a new high.
      start_game();
      check("g2_state", 32'(state), 32'(S_PLAY));
      check("g2_lives", 32'(lives), 3);
      check("g2_new_high_clr", 32'(new_high), 0);
      hit_cycle();
      hit_cycle();
      hit_cycle();
      check("g2_over_state", 32'(state), 32'(S_OVER));
      check("g2_new_high", 32'(new_high), 0);
      check("g2_high", 32'(high_score), 17);

      // Game 3: reset while in HIT.
      repeat (120) frame();
      start_game();
      check("g3_attract", 32'(state), 32'(S_ATTRACT));
      start_game();
      check("g3_play", 32'(state), 32'(S_PLAY));
      collision = 1'b1;
      step();
      collision = 1'b0;
      repeat (5) frame();
      check("g3_hit", 32'(state), 32'(S_HIT));
      check("g3_high_pre", 32'(high_score), 17);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_state", 32'(state), 32'(S_ATTRACT));
      check("midrst_lives", 32'(lives), 0);
      check("midrst_high", 32'(high_score), 0);
      check("midrst_flash", 32'(flash), 0);
      check("midrst_scroll_reset", 32'(scroll_reset), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
